// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: bundles both requester handshakes and the shared adder
// connection. The master side is the requesters plus the external adder;
// the slave side is the arbiter itself.
interface adder_arbiter_if #(
  parameter int WIDTH = 5
);
  logic             req0;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] y0;
  logic             ack0;
  logic [WIDTH-1:0] s0;
  logic             c0;

  logic             req1;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic             ack1;
  logic [WIDTH-1:0] s1;
  logic             c1;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic [WIDTH-1:0] add_s;
  logic             add_c5;

  logic             busy;
  logic             owner;

  modport master (
    output req0, x0, y0, req1, x1, y1, add_s, add_c5,
    input  ack0, s0, c0, ack1, s1, c1, add_x, add_y, busy, owner
  );

  modport slave (
    input  req0, x0, y0, req1, x1, y1, add_s, add_c5,
    output ack0, s0, c0, ack1, s1, c1, add_x, add_y, busy, owner
  );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one external combinational adder between two
// requesters. The granted operands are registered onto the adder, held for
// SETTLE cycles while the carry ripples, then sum/carry are captured for the
// owner and a one-cycle ack is returned. Round-robin pointer breaks ties.
module adder_arbiter #(
  parameter int WIDTH  = 5,
  parameter int SETTLE = 1
) (
  input logic           clk,
  input logic           rst_n,
  adder_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             ptr, ptr_nxt;
  logic             owner, owner_nxt;
  logic             busy, busy_nxt;
  logic             ack0, ack0_nxt;
  logic             ack1, ack1_nxt;
  logic             c0, c0_nxt;
  logic             c1, c1_nxt;
  logic [WIDTH-1:0] s0, s0_nxt;
  logic [WIDTH-1:0] s1, s1_nxt;
  logic [WIDTH-1:0] add_x, add_x_nxt;
  logic [WIDTH-1:0] add_y, add_y_nxt;
  logic             gnt;

  // With both requesting the pointer decides; otherwise whoever is asking wins.
  assign gnt = (bus.req0 && bus.req1) ? ptr : bus.req1;

  assign bus.ack0  = ack0;
  assign bus.ack1  = ack1;
  assign bus.s0    = s0;
  assign bus.c0    = c0;
  assign bus.s1    = s1;
  assign bus.c1    = c1;
  assign bus.add_x = add_x;
  assign bus.add_y = add_y;
  assign bus.busy  = busy;
  assign bus.owner = owner;

  // Next-state and next-register values; every register holds unless changed.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    busy_nxt  = busy;
    ack0_nxt  = ack0;
    ack1_nxt  = ack1;
    c0_nxt    = c0;
    c1_nxt    = c1;
    s0_nxt    = s0;
    s1_nxt    = s1;
    add_x_nxt = add_x;
    add_y_nxt = add_y;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          add_x_nxt = gnt ? bus.x1 : bus.x0;
          add_y_nxt = gnt ? bus.y1 : bus.y0;
          owner_nxt = gnt;
          ptr_nxt   = ~gnt;
          cnt_nxt   = SETTLE_CNT;
          busy_nxt  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          if (owner) begin
            s1_nxt   = bus.add_s;
            c1_nxt   = bus.add_c5;
            ack1_nxt = 1'b1;
          end else begin
            s0_nxt   = bus.add_s;
            c0_nxt   = bus.add_c5;
            ack0_nxt = 1'b1;
          end
          state_nxt = DONE;
        end
      end
      DONE: begin
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ptr   <= 1'b0;
      owner <= 1'b0;
      busy  <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      c0    <= 1'b0;
      c1    <= 1'b0;
      s0    <= '0;
      s1    <= '0;
      add_x <= '0;
      add_y <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      busy  <= busy_nxt;
      ack0  <= ack0_nxt;
      ack1  <= ack1_nxt;
      c0    <= c0_nxt;
      c1    <= c1_nxt;
      s0    <= s0_nxt;
      s1    <= s1_nxt;
      add_x <= add_x_nxt;
      add_y <= add_y_nxt;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: two arbiters (SETTLE=1 and SETTLE=3), each with its own
// behavioural 5-bit adder, driven by a vector table and hand-written
// sequences for arbitration, settle timing and reset-in-flight.
module tb_adder_arbiter;

  localparam int W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int exp_s[2];
  int exp_c[2];

  typedef struct {
    bit         sel;
    logic [4:0] x;
    logic [4:0] y;
    logic [4:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[8];

  adder_arbiter_if #(.WIDTH(W)) bus_a ();
  adder_arbiter_if #(.WIDTH(W)) bus_b ();

  // The external ripple adders, carry-in tied low.
  assign {bus_a.add_c5, bus_a.add_s} = {1'b0, bus_a.add_x} + {1'b0, bus_a.add_y};
  assign {bus_b.add_c5, bus_b.add_s} = {1'b0, bus_b.add_x} + {1'b0, bus_b.add_y};

  adder_arbiter #(.WIDTH(W), .SETTLE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  adder_arbiter #(.WIDTH(W), .SETTLE(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case a sequence wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clearModel();
    exp_s[0] = 0; exp_s[1] = 0;
    exp_c[0] = 0; exp_c[1] = 0;
  endtask

  task automatic resetAll();
    rst_n = 1'b0;
    bus_a.req0 = 0; bus_a.req1 = 0;
    bus_b.req0 = 0; bus_b.req1 = 0;
    tick();
    tick();
    rst_n = 1'b1;
    clearModel();
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, "_ack0"}, bus_a.ack0, 0);
    checkOutput({tag, "_ack1"}, bus_a.ack1, 0);
    checkOutput({tag, "_s0"}, bus_a.s0, 0);
    checkOutput({tag, "_s1"}, bus_a.s1, 0);
    checkOutput({tag, "_c0"}, bus_a.c0, 0);
    checkOutput({tag, "_c1"}, bus_a.c1, 0);
    checkOutput({tag, "_add_x"}, bus_a.add_x, 0);
    checkOutput({tag, "_add_y"}, bus_a.add_y, 0);
    checkOutput({tag, "_busy"}, bus_a.busy, 0);
    checkOutput({tag, "_owner"}, bus_a.owner, 0);
  endtask

  // Ticks until instance A acks, bounded; n is the number of edges taken.
  task automatic waitAck(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus_a.ack0 || bus_a.ack1) && n < 20);
  endtask

  // One single-requester operation on instance A with full checking.
  task automatic applyStimulus(input vec_t v);
    int n;
    if (v.sel) begin
      bus_a.req1 = 1; bus_a.x1 = v.x; bus_a.y1 = v.y;
    end else begin
      bus_a.req0 = 1; bus_a.x0 = v.x; bus_a.y0 = v.y;
    end
    tick();
    n = 1;
    checkOutput("op_busy", bus_a.busy, 1);
    checkOutput("op_owner", bus_a.owner, v.sel);
    checkOutput("op_add_x", bus_a.add_x, v.x);
    checkOutput("op_add_y", bus_a.add_y, v.y);
    while (!(bus_a.ack0 || bus_a.ack1) && n < 20) begin
      tick();
      n++;
    end
    checkOutput("op_latency", n, 2);
    checkOutput("op_ack_sel", v.sel ? bus_a.ack1 : bus_a.ack0, 1);
    checkOutput("op_ack_other", v.sel ? bus_a.ack0 : bus_a.ack1, 0);
    checkOutput("op_sum", v.sel ? bus_a.s1 : bus_a.s0, v.s);
    checkOutput("op_carry", v.sel ? bus_a.c1 : bus_a.c0, v.c);
    checkOutput("op_other_sum", v.sel ? bus_a.s0 : bus_a.s1, exp_s[v.sel ? 0 : 1]);
    checkOutput("op_other_carry", v.sel ? bus_a.c0 : bus_a.c1, exp_c[v.sel ? 0 : 1]);
    exp_s[v.sel ? 1 : 0] = v.s;
    exp_c[v.sel ? 1 : 0] = v.c;
    bus_a.req0 = 0;
    bus_a.req1 = 0;
    tick();
    checkOutput("op_ack_cleared", bus_a.ack0 | bus_a.ack1, 0);
    checkOutput("op_busy_cleared", bus_a.busy, 0);
  endtask

  initial begin
    int n;
    int who;

    vecs[0] = '{1'b0, 5'd7,  5'd8,  5'd15, 1'b0};
    vecs[1] = '{1'b1, 5'd31, 5'd1,  5'd0,  1'b1};
    vecs[2] = '{1'b1, 5'd15, 5'd15, 5'd30, 1'b0};
    vecs[3] = '{1'b0, 5'd31, 5'd31, 5'd30, 1'b1};
    vecs[4] = '{1'b0, 5'd16, 5'd16, 5'd0,  1'b1};
    vecs[5] = '{1'b1, 5'd0,  5'd31, 5'd31, 1'b0};
    vecs[6] = '{1'b0, 5'd19, 5'd13, 5'd0,  1'b1};
    vecs[7] = '{1'b1, 5'd20, 5'd11, 5'd31, 1'b0};

    bus_a.x0 = 0; bus_a.y0 = 0; bus_a.x1 = 0; bus_a.y1 = 0;
    bus_b.x0 = 0; bus_b.y0 = 0; bus_b.x1 = 0; bus_b.y1 = 0;
    resetAll();
    $display("[TB] reset state");
    checkResetA("rst");
    checkOutput("rst_b_busy", bus_b.busy, 0);
    checkOutput("rst_b_add_x", bus_b.add_x, 0);

    $display("[TB] single-requester vector table");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    $display("[TB] simultaneous requests and fairness");
    resetAll();
    bus_a.req0 = 1; bus_a.x0 = 5'd3;  bus_a.y0 = 5'd4;
    bus_a.req1 = 1; bus_a.x1 = 5'd10; bus_a.y1 = 5'd20;
    for (int k = 0; k < 4; k++) begin
      waitAck(n);
      who = bus_a.ack1 ? 1 : 0;
      checkOutput("fair_gap", n, (k == 0) ? 2 : 3);
      checkOutput("fair_order", who, k % 2);
      checkOutput("fair_both_acks", bus_a.ack0 & bus_a.ack1, 0);
      checkOutput("fair_owner", bus_a.owner, k % 2);
      checkOutput("fair_sum", who ? bus_a.s1 : bus_a.s0, (k % 2) ? 30 : 7);
      checkOutput("fair_carry", who ? bus_a.c1 : bus_a.c0, 0);
    end
    bus_a.req0 = 0;
    bus_a.req1 = 0;
    tick();
    checkOutput("fair_busy_end", bus_a.busy, 0);
    exp_s[0] = 7; exp_s[1] = 30;
    applyStimulus('{1'b1, 5'd9, 5'd9, 5'd18, 1'b0});
    applyStimulus('{1'b0, 5'd20, 5'd5, 5'd25, 1'b0});

    $display("[TB] SETTLE=3 instance");
    bus_b.req0 = 1; bus_b.x0 = 5'd12; bus_b.y0 = 5'd9;
    tick();
    bus_b.x0 = 5'd0;
    bus_b.req0 = 0;
    for (int k = 1; k <= 3; k++) begin
      checkOutput("s3_add_x_held", bus_b.add_x, 12);
      checkOutput("s3_add_y_held", bus_b.add_y, 9);
      checkOutput("s3_no_early_ack", bus_b.ack0, 0);
      checkOutput("s3_busy", bus_b.busy, 1);
      tick();
    end
    checkOutput("s3_ack0", bus_b.ack0, 1);
    checkOutput("s3_ack1", bus_b.ack1, 0);
    checkOutput("s3_sum", bus_b.s0, 21);
    checkOutput("s3_carry", bus_b.c0, 0);
    checkOutput("s3_s1_untouched", bus_b.s1, 0);
    tick();
    checkOutput("s3_ack_pulse", bus_b.ack0, 0);
    checkOutput("s3_busy_end", bus_b.busy, 0);

    $display("[TB] reset during WAIT");
    bus_a.req0 = 1; bus_a.x0 = 5'd5; bus_a.y0 = 5'd6;
    tick();
    checkOutput("midrst_busy_pre", bus_a.busy, 1);
    rst_n = 1'b0;
    bus_a.req0 = 0;
    tick();
    checkResetA("midrst");
    rst_n = 1'b1;
    tick();
    checkOutput("midrst_no_ack", bus_a.ack0 | bus_a.ack1, 0);
    checkOutput("midrst_idle", bus_a.busy, 0);
    clearModel();
    applyStimulus('{1'b1, 5'd1, 5'd2, 5'd3, 1'b0});

    bus_a.req0 = 1; bus_a.x0 = 5'd2; bus_a.y0 = 5'd2;
    bus_a.req1 = 1; bus_a.x1 = 5'd4; bus_a.y1 = 5'd4;
    waitAck(n);
    checkOutput("regain_first", bus_a.ack0, 1);
    checkOutput("regain_s0", bus_a.s0, 4);
    bus_a.req0 = 0;
    waitAck(n);
    checkOutput("regain_gap", n, 3);
    checkOutput("regain_second", bus_a.ack1, 1);
    checkOutput("regain_s1", bus_a.s1, 8);
    bus_a.req1 = 0;
    tick();
    checkOutput("regain_busy_end", bus_a.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Sequencing and arbitration controller that shares one combinational 5-bit ripple adder (X, Y -> S, C5) between two requesters. It registers the granted requester's operands onto the adder inputs, waits a programmable settle time for the carry chain to ripple, captures sum and carry-out, and returns them to that requester with a one-cycle acknowledge. It sits between the requesting logic and the adder instance; the adder itself is external.

## Interface

- WIDTH, 5: operand/sum width; must match the attached adder.
- SETTLE, 1: cycles the adder inputs are held before the result is sampled; legal range 1..15.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req0  in  1  requester 0 request; held high with stable x0/y0 until ack0.
- x0, y0  in  WIDTH  requester 0 operands.
- ack0  out  1  one-cycle pulse: s0/c0 valid from this cycle.
- s0  out  WIDTH  requester 0 last sum; held until its next completion.
- c0  out  1  requester 0 last carry-out (C5).
- req1, x1, y1, ack1, s1, c1: same as above for requester 1.
- add_x, add_y  out  WIDTH  registered operands driven to the adder.
- add_s  in  WIDTH  adder sum.
- add_c5  in  1  adder carry-out.
- busy  out  1  high while not in IDLE.
- owner  out  1  requester currently or last served (0/1).

## Operation

- All outputs registered. Reset values: ack0=ack1=0, s0=s1=0, c0=c1=0, add_x=add_y=0, busy=0, owner=0; state=IDLE, priority pointer=0, settle counter=0.
- States: IDLE, WAIT, DONE.
- IDLE: if neither req is high, stay. If exactly one is high, grant it. If both are high, grant the requester named by the priority pointer. On grant: add_x/add_y <= granted operands, owner <= granted id, counter <= SETTLE, pointer <= other id, busy <= 1, -> WAIT.
- WAIT: counter decrements each cycle. At the counter==1 edge: s_owner <= add_s, c_owner <= add_c5, ack_owner <= 1, -> DONE. The other requester's s/c remain unchanged.
- DONE: ack_owner <= 0, busy <= 0, -> IDLE. req inputs are ignored in DONE.
- Arithmetic: sum is (x+y) mod 2^WIDTH, carry is bit WIDTH of the true sum. There is no carry-in; the adder's LSB carry-in is tied 0.
- Round-robin: the pointer toggles only on a grant. A single requester can be served repeatedly when the other is idle.
- req still high in the IDLE cycle after DONE counts as a new request and is arbitrated normally.
- req dropped or operands changed during WAIT: the operation completes on the latched operands and ack still pulses.
- Reset during WAIT or DONE: the operation is abandoned, no ack is issued, and every register returns to its reset value on that edge.

## Timing

- Request latency: req sampled high in IDLE at edge E gives ack high in the cycle after edge E+SETTLE. With SETTLE=1, ack is high 2 cycles after req is first seen.
- Throughput: one operation per SETTLE+2 cycles. With SETTLE=1 and both requesting continuously, grants alternate 0,1,0,1 every 3 cycles.
- add_x/add_y are stable for exactly SETTLE full cycles before the result is sampled.
- ack is a single-cycle pulse. ack0 and ack1 are never high in the same cycle.
- A requester must deassert req in the cycle after it sees ack, or it is treated as a new request.

## Test plan

- Single op, SETTLE=1: req0 with x0=7, y0=8 -> ack0 pulses 2 cycles after req0 is seen, s0=15, c0=0, s1/c1 stay 0, busy high for 2 cycles.
- Overflow: req1 with x1=31, y1=1 -> s1=0, c1=1. Then x1=15, y1=15 -> s1=30, c1=0.
- Simultaneous requests after reset: req0 (3+4) and req1 (10+20) both held high -> requester 0 is served first (s0=7), requester 1 next (s1=30), acks 3 cycles apart, owner 0 then 1.
- Fairness: both reqs held high for 4 operations -> grant order is 0,1,0,1. req1 alone then req0 alone -> each is served immediately.
- SETTLE=3: req0 with 12+9 -> add_x=12, add_y=9 held 3 cycles, ack0 is seen 4 cycles after req0, s0=21.
- Reset mid-op: rst_n low during WAIT -> no ack, all outputs 0 next cycle. After release, a req1 of 1+2 completes with s1=3, and with both requesting, requester 0 regains priority.
